// File: rtl/ysyx_23060077_pkg.sv
// Shared definitions for the ysyx_23060077 core.
// Holds the data width, the default reset PC and the PCU fetch-sequencer
// state encodings (IDLE/REQ/WAIT/HOLD).
package ysyx_23060077_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned STATE_W = 2;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h3000_0000;

    // Fetch sequencer states
    localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] S_REQ  = 2'd1;
    localparam logic [STATE_W-1:0] S_WAIT = 2'd2;
    localparam logic [STATE_W-1:0] S_HOLD = 2'd3;

endpackage

// File: rtl/ysyx_23060077_pcu_target.sv
// Redirect target selection for the PCU (purely combinational).
// Priority trap > mret > EX control transfer.
// Optional feature macro: YSYX_23060077_PCU_MISALIGN_EN -- when defined, an
// EX-sourced target with bit 1 set is suppressed as a redirect and flagged
// on misalign_c instead.
// Ports:
//   trap_valid/trap_vec, mret_valid/mepc   CSR redirect requests
//   ex_valid, branch_taken, ex_jal, ex_jalr EX control-transfer qualifiers
//   ex_pc, ex_imm, ex_rs1                   EX operands for target adders
//   redirect_c  effective redirect this cycle
//   target_c    selected redirect target
//   misalign_c  EX target misaligned (always 0 when feature disabled)
module ysyx_23060077_pcu_target
    import ysyx_23060077_pkg::*;
(
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            mret_valid,
    input  logic [XLEN-1:0] mepc,
    input  logic            ex_valid,
    input  logic            branch_taken,
    input  logic            ex_jal,
    input  logic            ex_jalr,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    output logic            redirect_c,
    output logic [XLEN-1:0] target_c,
    output logic            misalign_c
);

    logic            ex_redir;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] ex_tgt;

    assign ex_redir = ex_valid & (branch_taken | ex_jal | ex_jalr);
    assign jalr_sum = ex_rs1 + ex_imm;

    // JALR clears bit 0 of the sum; branch and JAL are PC-relative
    assign ex_tgt = ex_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (ex_pc + ex_imm);

    assign target_c = trap_valid ? trap_vec :
                      mret_valid ? mepc     : ex_tgt;

`ifdef YSYX_23060077_PCU_MISALIGN_EN
    logic ex_sel;

    // Only an EX-selected target is checked; CSR targets are trusted
    assign ex_sel     = ~trap_valid & ~mret_valid & ex_redir;
    assign misalign_c = ex_sel & ex_tgt[1];
`else
    assign misalign_c = 1'b0;
`endif

    assign redirect_c = trap_valid | mret_valid | (ex_redir & ~misalign_c);

endmodule

// File: rtl/ysyx_23060077_pcu.sv
// Program-counter and fetch-sequencing unit.
// Owns the fetch PC, issues one fetch at a time over a valid/ready
// handshake, buffers the returned instruction for the IDU and applies
// trap/mret/EX redirects, killing any in-flight fetch and pulsing flush.
// Optional feature macro: YSYX_23060077_PCU_MISALIGN_EN (misaligned EX
// targets raise misalign_exc instead of redirecting).
// Ports:
//   clock, reset                 clock, synchronous active-high reset
//   ex_*/branch_taken            EX control-transfer inputs
//   trap_*/mret_valid/mepc       CSR redirect inputs
//   if_valid/if_pc/if_ready      fetch request handshake
//   if_done/if_inst              fetch response
//   id_valid/id_pc/id_inst/id_ready  buffered instruction to IDU
//   flush                        one-cycle pipeline flush pulse
//   misalign_exc/misalign_tval   misaligned target report
module ysyx_23060077_pcu
    import ysyx_23060077_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ex_valid,
    input  logic            branch_taken,
    input  logic            ex_jal,
    input  logic            ex_jalr,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            mret_valid,
    input  logic [XLEN-1:0] mepc,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    input  logic            if_ready,
    input  logic            if_done,
    input  logic [XLEN-1:0] if_inst,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_inst,
    input  logic            id_ready,
    output logic            flush,
    output logic            misalign_exc,
    output logic [XLEN-1:0] misalign_tval
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    pc_nxt;
    logic               kill;
    logic               kill_nxt;
    logic [XLEN-1:0]    pend;
    logic [XLEN-1:0]    pend_nxt;
    logic [XLEN-1:0]    id_pc_nxt;
    logic [XLEN-1:0]    id_inst_nxt;

    logic               redirect_c;
    logic [XLEN-1:0]    target_c;
    logic               misalign_c;

    ysyx_23060077_pcu_target u_target (
        .trap_valid   (trap_valid),
        .trap_vec     (trap_vec),
        .mret_valid   (mret_valid),
        .mepc         (mepc),
        .ex_valid     (ex_valid),
        .branch_taken (branch_taken),
        .ex_jal       (ex_jal),
        .ex_jalr      (ex_jalr),
        .ex_pc        (ex_pc),
        .ex_imm       (ex_imm),
        .ex_rs1       (ex_rs1),
        .redirect_c   (redirect_c),
        .target_c     (target_c),
        .misalign_c   (misalign_c)
    );

    // Fetch address is the architectural PC; it only moves outside REQ,
    // so a stalled request stays stable even across a redirect.
    assign if_pc = pc;

    // Next-state and next-value logic
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        kill_nxt    = kill;
        pend_nxt    = pend;
        id_pc_nxt   = id_pc;
        id_inst_nxt = id_inst;

        case (state)
            S_IDLE: begin
                state_nxt = S_REQ;
                if (redirect_c) begin
                    pc_nxt = target_c;
                end
            end

            S_REQ: begin
                // Request may already be visible to the IFU: defer via kill
                if (redirect_c) begin
                    kill_nxt = 1'b1;
                    pend_nxt = target_c;
                end
                if (if_ready) begin
                    state_nxt = S_WAIT;
                end
            end

            S_WAIT: begin
                if (redirect_c) begin
                    kill_nxt = 1'b1;
                    pend_nxt = target_c;
                end
                if (if_done) begin
                    if (redirect_c) begin
                        // Coincident redirect kills the returning instruction
                        pc_nxt    = target_c;
                        kill_nxt  = 1'b0;
                        state_nxt = S_REQ;
                    end else if (kill) begin
                        pc_nxt    = pend;
                        kill_nxt  = 1'b0;
                        state_nxt = S_REQ;
                    end else begin
                        id_pc_nxt   = pc;
                        id_inst_nxt = if_inst;
                        state_nxt   = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                // Redirect beats consumption: held instruction is dropped
                if (redirect_c) begin
                    pc_nxt    = target_c;
                    state_nxt = S_REQ;
                end else if (id_ready) begin
                    pc_nxt    = pc + XLEN'(4);
                    state_nxt = S_REQ;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            pc            <= RESET_PC;
            kill          <= 1'b0;
            pend          <= '0;
            if_valid      <= 1'b0;
            id_valid      <= 1'b0;
            id_pc         <= '0;
            id_inst       <= '0;
            flush         <= 1'b0;
            misalign_exc  <= 1'b0;
            misalign_tval <= '0;
        end else begin
            state         <= state_nxt;
            pc            <= pc_nxt;
            kill          <= kill_nxt;
            pend          <= pend_nxt;
            if_valid      <= (state_nxt == S_REQ);
            id_valid      <= (state_nxt == S_HOLD);
            id_pc         <= id_pc_nxt;
            id_inst       <= id_inst_nxt;
            flush         <= redirect_c;
            misalign_exc  <= misalign_c;
            misalign_tval <= misalign_c ? target_c : '0;
        end
    end

endmodule

// File: tb/tb_ysyx_23060077_pcu.sv
// Self-checking bench for ysyx_23060077_pcu: per-cycle vector table for the
// fetch/redirect flow plus hand-written stall, overwrite and reset sequences.
// Expectations follow YSYX_23060077_PCU_MISALIGN_EN when it is defined.
module tb_ysyx_23060077_pcu;

    localparam logic [2:0] K_NONE   = 3'd0;
    localparam logic [2:0] K_BR     = 3'd1;
    localparam logic [2:0] K_JAL    = 3'd2;
    localparam logic [2:0] K_JALR   = 3'd3;
    localparam logic [2:0] K_TRAP   = 3'd4;
    localparam logic [2:0] K_MRET   = 3'd5;
    localparam logic [2:0] K_TRAPBR = 3'd6;

    typedef struct packed {
        logic [2:0]  kind;
        logic [31:0] opa;
        logic [31:0] opb;
        logic        rdy;
        logic        done;
        logic [31:0] inst;
        logic        idr;
        logic        e_iv;
        logic [31:0] e_ipc;
        logic        e_dv;
        logic [31:0] e_dpc;
        logic [31:0] e_dinst;
        logic        e_fl;
        logic        e_mis;
        logic [31:0] e_tval;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        ex_valid, branch_taken, ex_jal, ex_jalr;
    logic [31:0] ex_pc, ex_imm, ex_rs1;
    logic        trap_valid, mret_valid;
    logic [31:0] trap_vec, mepc;
    logic        if_valid, if_ready, if_done;
    logic [31:0] if_pc, if_inst;
    logic        id_valid, id_ready;
    logic [31:0] id_pc, id_inst;
    logic        flush, misalign_exc;
    logic [31:0] misalign_tval;

    int tests  = 0;
    int errors = 0;

    vec_t tbl [19];

    always #5 clock = ~clock;

    ysyx_23060077_pcu dut (
        .clock         (clock),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .branch_taken  (branch_taken),
        .ex_jal        (ex_jal),
        .ex_jalr       (ex_jalr),
        .ex_pc         (ex_pc),
        .ex_imm        (ex_imm),
        .ex_rs1        (ex_rs1),
        .trap_valid    (trap_valid),
        .trap_vec      (trap_vec),
        .mret_valid    (mret_valid),
        .mepc          (mepc),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_ready      (if_ready),
        .if_done       (if_done),
        .if_inst       (if_inst),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_inst       (id_inst),
        .id_ready      (id_ready),
        .flush         (flush),
        .misalign_exc  (misalign_exc),
        .misalign_tval (misalign_tval)
    );

    function automatic vec_t mk(input logic [2:0] kind, input logic [31:0] opa, input logic [31:0] opb,
                                input logic rdy, input logic done, input logic [31:0] inst, input logic idr,
                                input logic e_iv, input logic [31:0] e_ipc, input logic e_dv,
                                input logic [31:0] e_dpc, input logic [31:0] e_dinst, input logic e_fl);
        vec_t v;
        v.kind = kind; v.opa = opa; v.opb = opb;
        v.rdy = rdy; v.done = done; v.inst = inst; v.idr = idr;
        v.e_iv = e_iv; v.e_ipc = e_ipc; v.e_dv = e_dv;
        v.e_dpc = e_dpc; v.e_dinst = e_dinst; v.e_fl = e_fl;
        v.e_mis = 1'b0; v.e_tval = 32'h0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ex_valid = 1'b0; branch_taken = 1'b0; ex_jal = 1'b0; ex_jalr = 1'b0;
        ex_pc = 32'h0; ex_imm = 32'h0; ex_rs1 = 32'h0;
        trap_valid = 1'b0; trap_vec = 32'h0; mret_valid = 1'b0; mepc = 32'h0;
        if_ready = v.rdy; if_done = v.done; if_inst = v.inst; id_ready = v.idr;
        case (v.kind)
            K_BR:     begin ex_valid = 1'b1; branch_taken = 1'b1; ex_pc = v.opa; ex_imm = v.opb; end
            K_JAL:    begin ex_valid = 1'b1; ex_jal = 1'b1; ex_pc = v.opa; ex_imm = v.opb; end
            K_JALR:   begin ex_valid = 1'b1; ex_jalr = 1'b1; ex_rs1 = v.opa; ex_imm = v.opb; end
            K_TRAP:   begin trap_valid = 1'b1; trap_vec = v.opa; end
            K_MRET:   begin mret_valid = 1'b1; mepc = v.opa; end
            K_TRAPBR: begin trap_valid = 1'b1; trap_vec = v.opa;
                            ex_valid = 1'b1; branch_taken = 1'b1; ex_pc = v.opb; end
            default:  ;
        endcase
    endtask

    task automatic check_out(input string name, input vec_t v);
        chk({name, ".if_valid"},      32'(if_valid),      32'(v.e_iv));
        chk({name, ".if_pc"},         if_pc,              v.e_ipc);
        chk({name, ".id_valid"},      32'(id_valid),      32'(v.e_dv));
        chk({name, ".id_pc"},         id_pc,              v.e_dpc);
        chk({name, ".id_inst"},       id_inst,            v.e_dinst);
        chk({name, ".flush"},         32'(flush),         32'(v.e_fl));
        chk({name, ".misalign_exc"},  32'(misalign_exc),  32'(v.e_mis));
        chk({name, ".misalign_tval"}, misalign_tval,      v.e_tval);
    endtask

    // Apply one cycle of stimulus at negedge, check the post-edge outputs
    task automatic step(input string name, input vec_t v);
        drive(v);
        @(posedge clock);
        @(negedge clock);
        check_out(name, v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] pc_c, dpc_c, dinst_c;
        logic        on;
        vec_t        z;
`ifdef YSYX_23060077_PCU_MISALIGN_EN
        on = 1'b1; pc_c = 32'h3000_0004; dpc_c = 32'h3000_0000; dinst_c = 32'hDEAD_BEEF;
`else
        on = 1'b0; pc_c = 32'h8000_0002; dpc_c = 32'h3000_0008; dinst_c = 32'h0020_0113;
`endif
        // Normal fetch: handshake, done two cycles later, IDU always ready
        tbl[0]  = mk(K_NONE, 0, 0, 0, 0, 0, 0,            1, 32'h3000_0000, 0, 32'h0, 32'h0, 0);
        tbl[1]  = mk(K_NONE, 0, 0, 1, 0, 0, 0,            0, 32'h3000_0000, 0, 32'h0, 32'h0, 0);
        tbl[2]  = mk(K_NONE, 0, 0, 0, 0, 0, 0,            0, 32'h3000_0000, 0, 32'h0, 32'h0, 0);
        tbl[3]  = mk(K_NONE, 0, 0, 0, 1, 32'h0000_0013, 0, 0, 32'h3000_0000, 1, 32'h3000_0000, 32'h0000_0013, 0);
        tbl[4]  = mk(K_NONE, 0, 0, 0, 0, 0, 1,            1, 32'h3000_0004, 0, 32'h3000_0000, 32'h0000_0013, 0);
        tbl[5]  = mk(K_NONE, 0, 0, 1, 0, 0, 0,            0, 32'h3000_0004, 0, 32'h3000_0000, 32'h0000_0013, 0);
        tbl[6]  = mk(K_NONE, 0, 0, 0, 0, 0, 0,            0, 32'h3000_0004, 0, 32'h3000_0000, 32'h0000_0013, 0);
        tbl[7]  = mk(K_NONE, 0, 0, 0, 1, 32'h0010_0093, 0, 0, 32'h3000_0004, 1, 32'h3000_0004, 32'h0010_0093, 0);
        tbl[8]  = mk(K_NONE, 0, 0, 0, 0, 0, 1,            1, 32'h3000_0008, 0, 32'h3000_0004, 32'h0010_0093, 0);
        tbl[9]  = mk(K_NONE, 0, 0, 1, 0, 0, 0,            0, 32'h3000_0008, 0, 32'h3000_0004, 32'h0010_0093, 0);
        tbl[10] = mk(K_NONE, 0, 0, 0, 0, 0, 0,            0, 32'h3000_0008, 0, 32'h3000_0004, 32'h0010_0093, 0);
        tbl[11] = mk(K_NONE, 0, 0, 0, 1, 32'h0020_0113, 0, 0, 32'h3000_0008, 1, 32'h3000_0008, 32'h0020_0113, 0);
        // Taken branch in HOLD together with id_ready: redirect wins, no pc+4
        tbl[12] = mk(K_BR, 32'h3000_0010, 32'hFFFF_FFF0, 0, 0, 0, 1, 1, 32'h3000_0000, 0, 32'h3000_0008, 32'h0020_0113, 1);
        tbl[13] = mk(K_NONE, 0, 0, 1, 0, 0, 0,            0, 32'h3000_0000, 0, 32'h3000_0008, 32'h0020_0113, 0);
        // JALR in WAIT to 0x8000_0002
        tbl[14] = mk(K_JALR, 32'h8000_0003, 32'h0, 0, 0, 0, 0, 0, 32'h3000_0000, 0, 32'h3000_0008, 32'h0020_0113, !on);
        tbl[14].e_mis  = on;
        tbl[14].e_tval = on ? 32'h8000_0002 : 32'h0;
        tbl[15] = mk(K_NONE, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, !on, on ? 32'h3000_0000 : 32'h8000_0002, on, dpc_c, dinst_c, 0);
        tbl[16] = mk(K_NONE, 0, 0, 0, 0, 0, 1,            1, pc_c, 0, dpc_c, dinst_c, 0);
        // Trap and branch together in REQ with handshake: trap target wins
        tbl[17] = mk(K_TRAPBR, 32'h3000_0100, 32'h3000_0040, 1, 0, 0, 0, 0, pc_c, 0, dpc_c, dinst_c, 1);
        tbl[18] = mk(K_NONE, 0, 0, 0, 1, 32'h1111_1111, 0, 1, 32'h3000_0100, 0, dpc_c, dinst_c, 0);

        z = mk(K_NONE, 0, 0, 0, 0, 0, 0, 0, 32'h3000_0000, 0, 32'h0, 32'h0, 0);
        reset = 1'b1;
        drive(z);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_out("reset", z);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            step($sformatf("vec%0d", i), tbl[i]);
        end

        // Stalled REQ: redirects while if_ready=0, latest target wins
        step("stall1", mk(K_BR, 32'h3000_0200, 32'h40, 0, 0, 0, 0, 1, 32'h3000_0100, 0, dpc_c, dinst_c, 1));
        step("stall2", mk(K_MRET, 32'h3000_0300, 0, 0, 0, 0, 0, 1, 32'h3000_0100, 0, dpc_c, dinst_c, 1));
        step("stall3", mk(K_NONE, 0, 0, 0, 0, 0, 0, 1, 32'h3000_0100, 0, dpc_c, dinst_c, 0));
        step("stall4", mk(K_NONE, 0, 0, 1, 0, 0, 0, 0, 32'h3000_0100, 0, dpc_c, dinst_c, 0));
        step("stall5", mk(K_NONE, 0, 0, 0, 1, 32'h2222_2222, 0, 1, 32'h3000_0300, 0, dpc_c, dinst_c, 0));

        // Reset asserted in WAIT; stale responses afterwards are ignored
        step("rst_hs", mk(K_NONE, 0, 0, 1, 0, 0, 0, 0, 32'h3000_0300, 0, dpc_c, dinst_c, 0));
        reset = 1'b1;
        step("rst_wait", mk(K_NONE, 0, 0, 0, 1, 32'h3333_3333, 0, 0, 32'h3000_0000, 0, 32'h0, 32'h0, 0));
        reset = 1'b0;
        step("idle_jal", mk(K_JAL, 32'h3000_0000, 32'h20, 0, 1, 32'h4444_4444, 0, 1, 32'h3000_0020, 0, 32'h0, 32'h0, 1));
        step("late_done", mk(K_NONE, 0, 0, 0, 1, 32'h5555_5555, 0, 1, 32'h3000_0020, 0, 32'h0, 32'h0, 0));
        step("post_hs", mk(K_NONE, 0, 0, 1, 0, 0, 0, 0, 32'h3000_0020, 0, 32'h0, 32'h0, 0));
        step("post_done", mk(K_NONE, 0, 0, 0, 1, 32'h6666_6666, 0, 0, 32'h3000_0020, 1, 32'h3000_0020, 32'h6666_6666, 0));

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_23060077_pcu.md
# ysyx_23060077_pcu

Program-counter and fetch-sequencing unit. Consumes `branch_taken` from the EX-stage branch unit, jump and trap/mret redirects from EX/CSR, and owns the architectural fetch PC. It issues fetch requests to the IFU over a valid/ready handshake and buffers the returned instruction for the IDU. On any redirect it kills in-flight or held instructions and pulses a pipeline flush.

## Interface
- `RESET_PC`, default 32'h3000_0000: PC loaded on reset.
- `clock`  in  1  system clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `ex_valid`  in  1  EX stage holds a valid control-transfer instruction this cycle.
- `branch_taken`  in  1  conditional branch resolved taken.
- `ex_jal`  in  1  JAL in EX.
- `ex_jalr`  in  1  JALR in EX.
- `ex_pc`  in  32  PC of the EX instruction.
- `ex_imm`  in  32  sign-extended immediate.
- `ex_rs1`  in  32  rs1 operand for JALR.
- `trap_valid`  in  1  CSR trap request.
- `trap_vec`  in  32  mtvec target.
- `mret_valid`  in  1  MRET retiring.
- `mepc`  in  32  MRET target.
- `if_valid`  out  1  fetch request valid.
- `if_pc`  out  32  fetch address.
- `if_ready`  in  1  IFU accepts request.
- `if_done`  in  1  fetch response valid (one-cycle pulse).
- `if_inst`  in  32  fetched instruction, valid with `if_done`.
- `id_valid`  out  1  instruction available to IDU.
- `id_pc`  out  32  PC of `id_inst`.
- `id_inst`  out  32  buffered instruction.
- `id_ready`  in  1  IDU consumes instruction.
- `flush`  out  1  one-cycle pulse: clear IF/ID and ID/EX.
- `misalign_exc`  out  1  misaligned target detected (see Configuration).
- `misalign_tval`  out  32  offending target.

## Operation
- Redirect sources, priority trap > mret > EX. EX redirect = `ex_valid & (branch_taken | ex_jal | ex_jalr)`.
- Target: trap → `trap_vec`; mret → `mepc`; branch/JAL → `ex_pc + ex_imm`; JALR → `(ex_rs1 + ex_imm) & ~32'h1`. All adds 32-bit, wrap mod 2^32.
- States:
  - IDLE: entered on reset; next cycle → REQ.
  - REQ: `if_valid`=1; on `if_ready` → WAIT.
  - WAIT: on `if_done` capture `if_inst`/`if_pc` → HOLD.
  - HOLD: `id_valid`=1; on `id_ready`, `pc <= pc + 4` → REQ.
- Handshake: while `if_valid`=1 and `if_ready`=0, `if_pc` and `if_valid` stay stable, even across a redirect.
- Redirect handling, in the cycle the redirect is seen:
  - IDLE/HOLD: `pc <= target`; held instruction dropped; → REQ.
  - REQ (no handshake): record target in pending register, set `kill`; remain in REQ until handshake → WAIT.
  - WAIT, or REQ with handshake: set `kill`, record pending target.
  - On `if_done` with `kill`: response discarded, not presented to IDU; `pc <= pending`; clear `kill`; → REQ.
- Back-to-back redirects while pending: latest overwrites pending target.
- Redirect coincident with `if_done` in WAIT: the returning instruction is killed.
- Redirect coincident with `id_ready` in HOLD: redirect wins; no `pc+4`.

## Timing
- Reset values: `if_valid`=0, `if_pc`=`RESET_PC`, `id_valid`=0, `id_pc`=0, `id_inst`=0, `flush`=0, `misalign_exc`=0, `misalign_tval`=0, `kill`=0, state IDLE.
- First request: `if_valid` rises cycle 1 after reset deassertion.
- `flush` is registered: redirect seen in cycle N → `flush`=1 in cycle N+1 only.
- Redirect in IDLE/HOLD at N → `if_valid`=1, `if_pc`=target at N+1.
- `id_valid` rises the cycle after `if_done`.
- Steady-state throughput: one instruction per (handshake + fetch latency + 1 + IDU stall) cycles. No overlap of fetches; one outstanding fetch maximum.
- Reset asserted mid-operation overrides everything; any outstanding IFU response after reset is ignored until the first new handshake.

## Configuration
- `YSYX_23060077_PCU_MISALIGN_EN` defined:
  - EX redirect with `target[1]`=1 does not redirect.
  - Instead, `misalign_exc`=1 for cycle N+1 with `misalign_tval`=target.
  - No `flush`; the CSR raises a trap in response.
- Undefined: target used as computed; `misalign_exc`/`misalign_tval` tied 0.

## Structure
- Shared package `ysyx_23060077_pkg`: state encoding constants (IDLE/REQ/WAIT/HOLD), `RESET_PC` default, XLEN=32.
- One sub-module: `ysyx_23060077_pcu_target`, a combinational target mux and adders with priority select.

## Test plan
- Reset, `if_ready`=1, `if_done` 2 cycles after handshake, `id_ready`=1 → `if_pc` sequence 0x3000_0000, 0x3000_0004, 0x3000_0008; `id_inst` matches stimulus.
- Taken branch in HOLD, `ex_pc`=0x3000_0010, imm=0xFFFF_FFF0 → `flush` pulse, next `if_pc`=0x3000_0000, held instruction never consumed.
- JALR in WAIT, rs1=0x8000_0003, imm=0 → returning inst killed (`id_valid` stays 0), then `if_pc`=0x8000_0002 (macro off) or `misalign_exc`=1 with tval 0x8000_0002 and no `flush` (macro on).
- Trap and taken branch in same cycle, `trap_vec`=0x3000_0100 → `if_pc`=0x3000_0100.
- REQ with `if_ready`=0 for 3 cycles plus redirect in cycle 1 → `if_pc` stable until handshake; response killed; then target fetched.
- Reset asserted while in WAIT → all outputs return to reset values; late `if_done` produces no `id_valid`.
